seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display controller; next generation of the team's 8-digit hex scanner.
- Adds configurable digit count, per-digit decimal points, PWM brightness and tear-free frame-synchronous update.
- Uses a single clock domain with a synchronous scan tick, not a derived clock.
- Sits on the memory-mapped I/O bus: the CPU writes a value via cs, and the block drives anode select and segment lines on the board.

Parameters:
- NUM_DIGITS, 8: number of digits, range 1..16; non-power-of-two values are legal.
- DIV_BITS, 15: prescaler width; each digit slot lasts 2^DIV_BITS clk cycles.
- PWM_BITS, 3: brightness resolution; must be less than DIV_BITS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  write strobe; samples data_in, dp_in and bright
- data_in  in  4*NUM_DIGITS  hex nibbles; digit i = data_in[4i+3:4i]
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit
- bright  in  PWM_BITS  brightness code
- seg_out  out  8  active-low segments; [6:0] = g..a, [7] = dp
- sel_out  out  NUM_DIGITS  active-low digit select
- frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset state: prescaler = 0, idx = 0, shadow and active registers = 0, bright_act = all-ones, pending = 0, seg_out = 8'hFF, sel_out = all ones, frame_done = 0.
- Reset is honoured mid-frame and mid-write; the first select asserts after the first post-reset tick.
- Prescaler increments every clk. tick = (prescaler == all ones).
- On tick, idx advances: if idx == NUM_DIGITS-1, idx goes to 0 and it is a frame wrap; otherwise idx = idx+1.
- cs loads the shadow registers (data, dp, bright) and sets pending. A later cs before the wrap overwrites the shadow; the last write wins.
- On a frame-wrap tick with pending = 1: copy shadow to active and clear pending.
- If cs and the wrap coincide, the cs value goes to shadow and pending stays 1; the active registers get the previous shadow. The new value is displayed one frame later.
- Active data never changes mid-frame, so no digit tearing.
- frame_done = 1 for exactly the clk after each wrap tick.
- Output path, registered, 1-cycle latency from idx/prescaler:
  - nibble = active_data[4*idx +: 4]; segment codes:
    - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
    - 8:80, 9:90, A:88, B:83, C:C6, D:A1, E:86, F:8E
  - seg_out[7] = ~active_dp[idx]; seg_out[6:0] = code[6:0].
  - on = (prescaler[DIV_BITS-1 -: PWM_BITS] <= bright_act); duty = (bright+1)/2^PWM_BITS, so all-ones = 100%.
  - sel_out = all ones except bit idx, which is 0 when on = 1.
  - When on = 0, sel_out = all ones and seg_out is unchanged.
- NUM_DIGITS = 1: idx stays 0; every tick is a wrap.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- When defined:
  - Digit i (i > 0) is blanked if active nibbles i..NUM_DIGITS-1 are all zero and active_dp[i..NUM_DIGITS-1] are all zero.
  - A blanked digit gives seg_out = 8'hFF; sel_out still scans normally.
  - Digit 0 is never blanked, so value 0 shows "0".
- When undefined: all digits show their nibble; behaviour is exactly as above.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment code constant array;
  - SEG_OFF = 8'hFF;
  - the function for idx width, $clog2 with a minimum of 1.
- One sub-module, seg7_hex_decode: a combinational nibble-to-segment decoder shared with other display blocks.
- Prescaler, scan FSM, shadow logic and PWM stay in the top module.

Test Plan (NUM_DIGITS=8, DIV_BITS=4, PWM_BITS=2):
- Reset release: seg_out = FF, sel_out = FF until the first tick (clk 16).
- Then sel_out = FE, and again FE on the 16 clks after the idx-0 slot begins. frame_done pulses every 128 clks.
- cs with data_in = 32'h89ABCDEF mid-frame: the current frame still shows the old value (0 -> C0 on all digits).
- After that write, once the next wrap passes: idx 0 shows 8E, idx 7 shows 80.
- Two cs writes (11111111, then 22222222) in one frame: only 22222222 (A4) appears after the wrap; 11111111 never appears.
- cs on the exact wrap-tick cycle: display changes one frame later.
- cs again in the next frame: the intermediate value is still shown for one full frame.
- bright = 0: the select is low for 4 of each 16-clk slot.
- bright = 3: the select is low for all 16 clks; seg_out is valid while selected.
- dp_in = 8'h04: only idx 2 has seg_out[7] = 0.
- With SEG7_LZ_BLANK_EN, data = 0000_0120: idx 3..7 show FF; idx 0..2 show C0/A4/F9.
- With SEG7_LZ_BLANK_EN, data = 0: idx 0 shows C0.
- Reset asserted mid-slot with pending = 1: outputs return to FF immediately; after reset, zeros are displayed and the pending write is lost.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed 7-segment display blocks.
//   SEG_CODES : active-low segment patterns for hex digits 0..F ([7]=dp off, [6:0]=g..a)
//   SEG_OFF   : all segments dark
//   scan_state_t : scan controller state encoding
//   idx_width : width of a digit index, never less than 1
package seg7_pkg;

  // Element n is the code for nibble n (packed, so element 15 is written first).
  localparam logic [15:0][7:0] SEG_CODES = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // SCAN_WAIT: after reset, outputs dark until the first prescaler tick.
  // SCAN_RUN : digits are being scanned.
  typedef enum logic {
    SCAN_WAIT = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low 7-segment decoder.
//   nibble : input  [3:0] hex value
//   seg    : output [6:0] active-low segments g..a
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_CODES[nibble];
    seg  = code[6:0];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with shadow/active registers,
// per-digit decimal points, PWM brightness and frame-synchronous update.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   cs         : write strobe; samples data_in, dp_in, bright into the shadow
//   data_in    : [4*NUM_DIGITS-1:0] hex nibbles, digit i = data_in[4i+3:4i]
//   dp_in      : [NUM_DIGITS-1:0] decimal points, 1 = lit
//   bright     : [PWM_BITS-1:0] brightness code, all-ones = 100% duty
//   seg_out    : [7:0] active-low segments, [7] = dp, [6:0] = g..a
//   sel_out    : [NUM_DIGITS-1:0] active-low digit select
//   frame_done : one-cycle pulse the clk after each frame wrap
//
// Handshake: cs is a single-cycle strobe with no ready; every cycle it is high
// is a write, and the last write before a frame wrap is the one displayed.
//
// Build option: define SEG7_LZ_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked).
//
// PWM_BITS must be less than DIV_BITS.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 15,
  parameter int PWM_BITS   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [PWM_BITS-1:0]     bright,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   sel_out,
  output logic                    frame_done
);

  localparam int              IDX_W    = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // ---------------- prescaler ----------------
  logic [DIV_BITS-1:0] prescaler;
  logic                tick;

  assign tick = &prescaler;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prescaler <= '0;
    else       prescaler <= prescaler + 1'b1;
  end

  // ---------------- scan FSM ----------------
  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN_WAIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The first tick after reset only starts the scan so digit 0 gets a full slot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      SCAN_WAIT: begin
        if (tick) state_d = SCAN_RUN;
      end
      SCAN_RUN: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = SCAN_WAIT;
    endcase
  end

  // ---------------- shadow / active registers ----------------
  logic [4*NUM_DIGITS-1:0] sh_data, act_data;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
  logic [PWM_BITS-1:0]     sh_bright, bright_act;
  logic                    pending;

  // A write coinciding with the wrap lands in the shadow only; the active set
  // takes the previous shadow, and the new value waits for the next wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_bright  <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      bright_act <= '1;
      pending    <= 1'b0;
    end else begin
      if (wrap && pending) begin
        act_data   <= sh_data;
        act_dp     <= sh_dp;
        bright_act <= sh_bright;
      end
      if (cs) begin
        sh_data   <= data_in;
        sh_dp     <= dp_in;
        sh_bright <= bright;
        pending   <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= wrap;
  end

  // ---------------- leading-zero blanking ----------------
  logic [NUM_DIGITS-1:0] blank;

`ifdef SEG7_LZ_BLANK_EN
  logic tail_zero;

  // Walk from the most significant digit down; a digit is blank while every
  // digit at or above it is a zero nibble with its dp dark.
  always_comb begin
    blank     = '0;
    tail_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero && (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
      blank[i]  = (i > 0) && tail_zero;
    end
  end
`else
  assign blank = '0;
`endif

  // ---------------- output path ----------------
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic                  pwm_on;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] sel_d;

  assign nibble = act_data[{idx_q, 2'b00} +: 4];
  assign pwm_on = (prescaler[DIV_BITS-1 -: PWM_BITS] <= bright_act);

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // While the PWM phase is off only the select is released; segments hold.
  always_comb begin
    seg_d = seg_out;
    sel_d = '1;
    if (state_q == SCAN_RUN && pwm_on) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = blank[idx_q] ? SEG_OFF : {~act_dp[idx_q], dec_seg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out <= SEG_OFF;
      sel_out <= '1;
    end else begin
      seg_out <= seg_d;
      sel_out <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl with
// NUM_DIGITS=8, DIV_BITS=4, PWM_BITS=2 (16-clk slots, 128-clk frames).
// Stimulus pushes the expected {sel_out, seg_out} of each digit slot of a
// frame into exp_q; the monitor pops one entry at the start of every slot.
module tb_seg7_scan_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs  = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in   = '0;
  logic [1:0]  bright  = 2'd3;
  logic [7:0]  seg_out;
  logic [7:0]  sel_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS (8),
    .DIV_BITS   (4),
    .PWM_BITS   (2)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .cs         (cs),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .bright     (bright),
    .seg_out    (seg_out),
    .sel_out    (sel_out),
    .frame_done (frame_done)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [7:0]  prev_sel = 8'hFF;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: seg_lut = 8'hC0;  4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;  4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;  4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;  4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;  4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;  4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;  4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;  default: seg_lut = 8'h8E;
    endcase
  endfunction

  function automatic logic [15:0] exp_slot(input logic [31:0] d, input logic [7:0] dp, input int i);
    logic [7:0] sel;
    logic [7:0] code;
    logic [7:0] seg;
    logic       tail_zero;
    sel    = 8'hFF;
    sel[i] = 1'b0;
    code   = seg_lut(d[4*i +: 4]);
    seg    = {~dp[i], code[6:0]};
    tail_zero = 1'b1;
    for (int j = i; j < 8; j++)
      if (d[4*j +: 4] != 4'h0 || dp[j]) tail_zero = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    if (i > 0 && tail_zero) seg = 8'hFF;
`endif
    return {sel, seg};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_slot(d, dp, i));
  endtask

  task automatic write_reg(input logic [31:0] d, input logic [7:0] dp, input logic [1:0] br);
    data_in = d;
    dp_in   = dp;
    bright  = br;
    cs      = 1'b1;
    @(negedge clk);
    cs      = 1'b0;
  endtask

  // Returns at the negedge where frame_done is high (start of a frame).
  task automatic next_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 300);
    if (!frame_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: got no frame_done expected pulse within 300 clks");
    end
  endtask

  // Counts selected cycles over the first slot of a frame, and segment
  // changes while the PWM phase is off.
  task automatic measure_duty(input int exp_on, input logic [7:0] exp_seg, input string name);
    int on_cnt;
    int seg_bad;
    on_cnt  = 0;
    seg_bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (sel_out != 8'hFF) on_cnt++;
      if (seg_out != exp_seg) seg_bad++;
    end
    check({name, "_on"}, on_cnt, exp_on);
    check({name, "_seg"}, seg_bad, 0);
  endtask

  // ---------------- monitor ----------------
  // A slot starts when a new digit select appears.
  always @(negedge clk) begin
    if (!rst && sel_out != 8'hFF && sel_out != prev_sel && exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      n_cmp++;
      if ({sel_out, seg_out} !== mon_exp) begin
        n_bad++;
        $display("FAIL slot: got sel=%h seg=%h expected sel=%h seg=%h",
                 sel_out, seg_out, mon_exp[15:8], mon_exp[7:0]);
      end
    end
    prev_sel <= sel_out;
  end

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int cnt;

    repeat (3) @(negedge clk);
    check("reset_sel", sel_out, 8'hFF);
    check("reset_seg", seg_out, 8'hFF);
    check("reset_frame_done", frame_done, 0);
    rst = 1'b0;

    // Dark for 16 clks, then digit 0 shows zero.
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (sel_out != 8'hFF || seg_out != 8'hFF) bad++;
    end
    check("reset_idle", bad, 0);
    @(negedge clk);
    check("first_select", sel_out, 8'hFE);
    check("first_seg", seg_out, 8'hC0);

    next_frame();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_done && cnt < 300);
    check("frame_period", cnt, 128);

    // Mid-frame write: this frame still shows zeros.
    push_frame(32'h0, 8'h00);
    measure_duty(16, 8'hC0, "duty_b3");
    repeat (20) @(negedge clk);
    write_reg(32'h89ABCDEF, 8'h00, 2'd3);

    // Two writes in one frame: last one wins.
    next_frame();
    push_frame(32'h89ABCDEF, 8'h00);
    repeat (10) @(negedge clk);
    write_reg(32'h11111111, 8'h00, 2'd3);
    repeat (40) @(negedge clk);
    write_reg(32'h22222222, 8'h00, 2'd3);

    // Write exactly on the wrap tick: visible one frame later.
    next_frame();
    push_frame(32'h22222222, 8'h00);
    repeat (127) @(negedge clk);
    data_in = 32'h33333333;
    dp_in   = 8'h00;
    bright  = 2'd3;
    cs      = 1'b1;
    @(negedge clk);
    cs      = 1'b0;
    check("wrap_align", frame_done, 1);
    push_frame(32'h22222222, 8'h00);

    // Intermediate value held a full frame; write dp and brightness 0.
    next_frame();
    push_frame(32'h33333333, 8'h00);
    repeat (20) @(negedge clk);
    write_reg(32'h55555555, 8'h04, 2'd0);

    next_frame();
    push_frame(32'h55555555, 8'h04);
    measure_duty(4, 8'h92, "duty_b0");
    repeat (20) @(negedge clk);
    write_reg(32'h00000120, 8'h00, 2'd2);

    next_frame();
    push_frame(32'h00000120, 8'h00);
    measure_duty(12, 8'hC0, "duty_b2");
    repeat (20) @(negedge clk);
    write_reg(32'h0, 8'h00, 2'd3);

    // Zero value, then a pending write lost to a mid-slot reset.
    next_frame();
    push_frame(32'h0, 8'h00);
    repeat (20) @(negedge clk);
    write_reg(32'hDEADBEEF, 8'hFF, 2'd1);
    repeat (98) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_async_sel", sel_out, 8'hFF);
    check("reset_async_seg", seg_out, 8'hFF);
    check("reset_async_frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    next_frame();
    push_frame(32'h0, 8'h00);
    measure_duty(16, 8'hC0, "duty_reset");
    next_frame();
    check("queue_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
